// File: rtl/merger_out_packer.sv
// Packs merger output tuples from a FIFO into AXI4-Stream beats of LP_SLOTS tuples,
// emitting a partial, zero-padded final beat when the job count is not a multiple of LP_SLOTS.
module merger_out_packer #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_TUPLE_WIDTH      = 128
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_areset,
  input  logic                            i_start,
  input  logic [31:0]                     i_num_tuples,
  input  logic                            fifo_empty,
  input  logic [C_TUPLE_WIDTH-1:0]        fifo_data,
  output logic                            fifo_deq,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int LP_SLOTS    = C_AXIS_TDATA_WIDTH / C_TUPLE_WIDTH;
  localparam int TUPLE_BYTES = C_TUPLE_WIDTH / 8;
  localparam int SLOT_W      = $clog2(LP_SLOTS + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LP_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;

  state_t                          state;
  logic [SLOT_W-1:0]               slot;
  logic [31:0]                     remaining;
  logic [C_AXIS_TDATA_WIDTH-1:0]   buffer;
  logic                            done;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] keep;

  assign fifo_deq = (state == FILL) && !fifo_empty && (remaining != 32'd0);

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_areset) begin
      state     <= IDLE;
      slot      <= '0;
      remaining <= '0;
      buffer    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_num_tuples != 32'd0) begin
              remaining <= i_num_tuples;
              slot      <= '0;
              buffer    <= '0;
              state     <= FILL;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FILL: begin
          if (fifo_deq) begin
            for (int i = 0; i < LP_SLOTS; i++) begin
              if (slot == SLOT_W'(i)) buffer[i*C_TUPLE_WIDTH +: C_TUPLE_WIDTH] <= fifo_data;
            end
            slot      <= slot + SLOT_W'(1);
            remaining <= remaining - 32'd1;
            if (slot == LAST_SLOT || remaining == 32'd1) state <= SEND;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (remaining != 32'd0) begin
              state  <= FILL;
              slot   <= '0;
              buffer <= '0;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In SEND, slot holds the number of filled slots, so it directly sizes tkeep.
  always_comb begin
    keep = '0;
    if (state == SEND) begin
      for (int i = 0; i < LP_SLOTS; i++) begin
        if (SLOT_W'(i) < slot) keep[i*TUPLE_BYTES +: TUPLE_BYTES] = '1;
      end
    end
  end

  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = buffer;
  assign m_axis_tkeep  = keep;
  assign m_axis_tlast  = (state == SEND) && (remaining == 32'd0);
  assign o_busy        = (state != IDLE);
  assign o_done        = done;

endmodule

// File: tb/tb_merger_out_packer.sv
// Scoreboard bench for merger_out_packer: a FIFO model feeds tuples, a reference model
// slices each job's tuple list into expected beats, and a negedge monitor checks every handshake.
module tb_merger_out_packer;
  localparam int D  = 512;
  localparam int TW = 128;
  localparam int K  = D / 8;
  localparam int NS = D / TW;

  typedef struct {
    logic [D-1:0] data;
    logic [K-1:0] keep;
    logic         last;
  } beat_t;

  logic          clk = 1'b0;
  logic          m_axis_areset = 1'b0;
  logic          i_start = 1'b0;
  logic [31:0]   i_num_tuples = '0;
  logic          fifo_empty = 1'b1;
  logic [TW-1:0] fifo_data = '0;
  logic          fifo_deq;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [D-1:0]  m_axis_tdata;
  logic [K-1:0]  m_axis_tkeep;
  logic          m_axis_tlast;
  logic          o_busy;
  logic          o_done;

  merger_out_packer #(.C_AXIS_TDATA_WIDTH(D), .C_TUPLE_WIDTH(TW)) dut (
    .m_axis_aclk(clk), .m_axis_areset(m_axis_areset), .i_start(i_start),
    .i_num_tuples(i_num_tuples), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_deq(fifo_deq), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int deq_cnt = 0;
  bit deq_seen = 1'b0;
  bit mon_en = 1'b1;
  bit stall = 1'b0;
  bit hold = 1'b0;
  beat_t held;
  beat_t mon_e;
  beat_t exp_q[$];
  logic [TW-1:0] fifo_q[$];

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic refresh();
    fifo_empty = stall || (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (deq_seen) begin
      if (fifo_q.size() != 0) fifo_q.delete(0);
      deq_cnt++;
    end
    refresh();
  endtask

  // Monitor: a handshake seen at negedge completes at the following rising edge.
  always @(negedge clk) begin
    deq_seen = fifo_deq && m_axis_areset;
    if (o_done) done_cnt++;
    if (!m_axis_areset || !mon_en) begin
      hold = 1'b0;
    end else begin
      if (hold)
        chk("stable_while_stalled", {m_axis_tdata, m_axis_tkeep, m_axis_tlast},
            {held.data, held.keep, held.last});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast},
              {mon_e.data, mon_e.keep, mon_e.last});
        end
      end
      hold = m_axis_tvalid && !m_axis_tready;
      held.data = m_axis_tdata;
      held.keep = m_axis_tkeep;
      held.last = m_axis_tlast;
    end
  end

  function automatic logic [TW-1:0] rnd_tuple();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: split the tuple list into groups of NS; each group is one beat.
  task automatic model_job(input int n, input bit seq);
    logic [TW-1:0] t[$];
    beat_t e;
    int nb;
    for (int i = 0; i < n; i++) t.push_back(seq ? TW'(i + 1) : rnd_tuple());
    foreach (t[i]) fifo_q.push_back(t[i]);
    nb = (n + NS - 1) / NS;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      e.keep = '0;
      for (int s = 0; s < NS; s++) begin
        if (b * NS + s < n) begin
          e.data[s*TW +: TW] = t[b*NS + s];
          e.keep[s*(TW/8) +: TW/8] = '1;
        end
      end
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  // smode: 0 FIFO never stalls, 1 random stalls, 2 six-cycle stall mid-beat.
  // rmode: 0 tready high, 1 random tready, 2 tready low for the first 14 cycles.
  task automatic run_job(input int n, input bit seq, input int smode, input int rmode,
                         input bit spurious);
    int c = 0;
    int d0 = 0;
    model_job(n, seq);
    deq_cnt = 0;
    done_cnt = 0;
    stall = 1'b0;
    i_start = 1'b1;
    i_num_tuples = n;
    refresh();
    step();
    i_start = 1'b0;
    while (done_cnt == 0 && c < 3000) begin
      case (rmode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = (c >= 14);
      endcase
      case (smode)
        0: stall = 1'b0;
        1: stall = ($urandom_range(0, 3) == 0);
        default: stall = (c >= 2 && c < 8);
      endcase
      if (smode == 2 && c == 2) d0 = deq_cnt;
      if (smode == 2 && c == 8) chk("stall_no_deq", deq_cnt, d0);
      if (spurious && c == 3 && o_busy) begin
        i_start = 1'b1;
        i_num_tuples = $urandom_range(1, 20);
      end else begin
        i_start = 1'b0;
      end
      refresh();
      step();
      c++;
    end
    i_start = 1'b0;
    stall = 1'b0;
    m_axis_tready = 1'b1;
    refresh();
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (3) step();
    chk("deq_count", deq_cnt, n);
    chk("done_once", done_cnt, 1);
    chk("beats_left", exp_q.size(), 0);
    chk("idle_after_job", o_busy, 0);
    exp_q.delete();
    fifo_q.delete();
    refresh();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_tvalid"}, m_axis_tvalid, 0);
    chk({nm, "_tdata"}, m_axis_tdata, 0);
    chk({nm, "_tkeep"}, m_axis_tkeep, 0);
    chk({nm, "_tlast"}, m_axis_tlast, 0);
    chk({nm, "_deq"}, fifo_deq, 0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_done"}, o_done, 0);
  endtask

  // Fill one beat of a job and stop with tvalid up and tready low.
  task automatic reach_send(input logic [31:0] n);
    int c = 0;
    for (int i = 0; i < NS; i++) fifo_q.push_back(rnd_tuple());
    m_axis_tready = 1'b0;
    i_start = 1'b1;
    i_num_tuples = n;
    refresh();
    step();
    i_start = 1'b0;
    while (!m_axis_tvalid && c < 50) begin
      step();
      c++;
    end
    chk("reach_send", m_axis_tvalid, 1);
  endtask

  initial begin
    m_axis_areset = 1'b0;
    refresh();
    repeat (3) step();
    chk_all_zero("reset");
    m_axis_areset = 1'b1;
    step();

    run_job(8, 1'b0, 0, 0, 1'b0);
    run_job(5, 1'b1, 0, 0, 1'b0);
    run_job(4, 1'b0, 0, 2, 1'b0);
    run_job(8, 1'b1, 2, 0, 1'b0);
    run_job(9, 1'b0, 0, 0, 1'b1);

    done_cnt = 0;
    i_start = 1'b1;
    i_num_tuples = 0;
    step();
    i_start = 1'b0;
    chk("zero_done_pulse", o_done, 1);
    chk("zero_no_tvalid", m_axis_tvalid, 0);
    repeat (2) step();
    chk("zero_done_once", done_cnt, 1);
    chk("zero_idle", o_busy, 0);

    for (int j = 0; j < 15; j++)
      run_job($urandom_range(1, 13), 1'b0, 1, 1, $urandom_range(0, 1));

    mon_en = 1'b0;
    reach_send(32'hFFFF_FFFF);
    chk("big_tlast", m_axis_tlast, 0);
    chk("big_tkeep", m_axis_tkeep, {K{1'b1}});
    m_axis_tready = 1'b1;
    step();
    chk("big_back_to_fill", {o_busy, m_axis_tvalid}, 2'b10);
    m_axis_areset = 1'b0;
    step();
    m_axis_areset = 1'b1;
    fifo_q.delete();
    refresh();
    step();

    done_cnt = 0;
    reach_send(4);
    m_axis_tready = 1'b1;
    m_axis_areset = 1'b0;
    step();
    chk_all_zero("midjob_reset");
    m_axis_areset = 1'b1;
    repeat (2) step();
    chk("midjob_no_done", done_cnt, 0);
    exp_q.delete();
    fifo_q.delete();
    refresh();
    mon_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end
endmodule
